// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: EX result in, dmem req/ack, formatted writeback pulse out
//
// Purpose:
//   Takes one execute-stage result per in_valid/in_ready handshake. ALU results
//   go straight to writeback one cycle later. Loads and stores hold a request on
//   the dmem req/ack interface until acked, then pulse writeback. The stage
//   accepts nothing while an access is outstanding. The request comes up the
//   cycle after acceptance, and writeback pulses the cycle after ack.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   EX result handshake; in_ready is high only in IDLE
//   alu_result          effective address for loads/stores, otherwise the result
//   store_data          rs2 value for stores
//   rd_in, reg_write_in destination register and its write enable
//   mem_we_in/mem_re_in store / load request (both set = store)
//   funct3_in           access size and sign
//   dmem_*              word-aligned request, lane-aligned wdata, byte strobes,
//                       ack with read data in the same cycle
//   wb_valid/wb_we      one-cycle writeback pulse and register write enable
//   wb_rd/wb_data       writeback register and value (held between pulses)
//   misalign            one-cycle flag for a rejected misaligned access
//
// Configuration:
//   MISALIGN_CHECK_EN   when defined, misaligned half/word accesses issue no
//                       request and retire next cycle with misalign=1, wb_we=0.
//                       When undefined, misalign is tied low, word accesses
//                       ignore the offset and half accesses use offset bit 1 only.

module mem_stage #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32,
  parameter int RF_SIZE = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] alu_result,
  input  logic [D_WIDTH-1:0] store_data,
  input  logic [RF_SIZE-1:0] rd_in,
  input  logic               reg_write_in,
  input  logic               mem_we_in,
  input  logic               mem_re_in,
  input  logic [2:0]         funct3_in,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [A_WIDTH-1:0] dmem_addr,
  output logic [D_WIDTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_wstrb,
  input  logic               dmem_ack,
  input  logic [D_WIDTH-1:0] dmem_rdata,
  output logic               wb_valid,
  output logic               wb_we,
  output logic [RF_SIZE-1:0] wb_rd,
  output logic [D_WIDTH-1:0] wb_data,
  output logic               misalign
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t state, state_next;

  logic               accept;
  logic               is_mem;
  logic               is_store;
  logic               mis;
  logic               rd_wen;
  logic [1:0]         off;
  logic [D_WIDTH-1:0] wdata_fmt;
  logic [3:0]         wstrb_fmt;

  // Load context captured at acceptance; formatting happens on ack.
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [RF_SIZE-1:0] rd_q;
  logic               wen_q;
  logic               store_q;

  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;
  logic [D_WIDTH-1:0] load_fmt;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = mem_we_in || mem_re_in;
  assign is_store = mem_we_in;
  assign off      = alu_result[1:0];
  assign rd_wen   = reg_write_in && (rd_in != '0);

  // Store lane formatting. Only funct3 000/001 are narrow; everything else is a word.
  always_comb begin
    wdata_fmt = store_data;
    wstrb_fmt = 4'b1111;
    case (funct3_in)
      3'b000: begin
        wdata_fmt = {(D_WIDTH/8){store_data[7:0]}};
        wstrb_fmt = 4'b0001 << off;
      end
      3'b001: begin
        wdata_fmt = {(D_WIDTH/16){store_data[15:0]}};
        wstrb_fmt = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (!is_store) wstrb_fmt = 4'b0000;
  end

  // Misalignment: stores size by the full funct3, loads by funct3[1:0]
  // (so LBU/LHU share the byte/half rules and 11x are word loads).
  always_comb begin
    mis = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (is_mem) begin
      if (is_store) begin
        case (funct3_in)
          3'b000:  mis = 1'b0;
          3'b001:  mis = off[0];
          default: mis = |off;
        endcase
      end else begin
        case (funct3_in[1:0])
          2'b00:   mis = 1'b0;
          2'b01:   mis = off[0];
          default: mis = |off;
        endcase
      end
    end
`endif
  end

  always_comb begin
    case (off_q)
      2'd0:    lane_byte = dmem_rdata[7:0];
      2'd1:    lane_byte = dmem_rdata[15:8];
      2'd2:    lane_byte = dmem_rdata[23:16];
      default: lane_byte = dmem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{(D_WIDTH-8){lane_byte[7]}}, lane_byte};
      3'b100:  load_fmt = {{(D_WIDTH-8){1'b0}}, lane_byte};
      3'b001:  load_fmt = {{(D_WIDTH-16){lane_half[15]}}, lane_half};
      3'b101:  load_fmt = {{(D_WIDTH-16){1'b0}}, lane_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !mis) state_next = ACCESS;
      ACCESS:  if (dmem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      misalign   <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      store_q    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      misalign <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (is_mem && !mis) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {alu_result[A_WIDTH-1:2], 2'b00};
            dmem_wdata <= wdata_fmt;
            dmem_wstrb <= wstrb_fmt;
            f3_q       <= funct3_in;
            off_q      <= off;
            rd_q       <= rd_in;
            wen_q      <= rd_wen && !is_store;
            store_q    <= is_store;
          end else begin
            // ALU result, or a rejected misaligned access retiring without a write.
            wb_valid <= 1'b1;
            wb_we    <= rd_wen && !mis;
            wb_rd    <= rd_in;
            wb_data  <= alu_result;
            misalign <= mis;
          end
        end
      end else if (dmem_ack) begin
        dmem_req <= 1'b0;
        wb_valid <= 1'b1;
        wb_we    <= wen_q;
        wb_rd    <= rd_q;
        if (!store_q) wb_data <= load_fmt;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed vectors

module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        mem_we_in;
  logic        mem_re_in;
  logic [2:0]  funct3_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        chk_rd;
    logic        chk_data;
  } exp_t;

  exp_t sb_q[$];

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_we_in(mem_we_in), .mem_re_in(mem_re_in),
    .funct3_in(funct3_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                              input logic mis, input logic crd, input logic cdata);
    exp_t e;
    e.we = we; e.rd = rd; e.data = data; e.mis = mis; e.chk_rd = crd; e.chk_data = cdata;
    return e;
  endfunction

  // Monitor: every writeback pulse consumes exactly one expected entry, in order.
  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got pulse rd=%0d data=%h expected no pulse", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("wb_we", wb_we, e.we);
        chk("wb_misalign", misalign, e.mis);
        if (e.chk_rd)   chk("wb_rd", wb_rd, e.rd);
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic we, input logic re, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [2:0] f3, input logic [4:0] rd, input logic rw);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1; mem_we_in = we; mem_re_in = re; alu_result = alu; store_data = sd;
    funct3_in = f3; rd_in = rd; reg_write_in = rw;
    @(posedge clk);
    #1 in_valid = 0; mem_we_in = 0; mem_re_in = 0;
  endtask

  // Issue a load/store, check the held request for delay+1 cycles, ack in the last one.
  task automatic mem_op(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [2:0] f3, input logic [4:0] rd, input logic rw, input int delay,
                        input logic [31:0] rdata, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [3:0] e_strb, input logic e_we, input logic [31:0] e_wb);
    sb_q.push_back(mk(e_we, rd, e_wb, 1'b0, !we, !we));
    issue(we, re, addr, sd, f3, rd, rw);
    for (int i = 0; i <= delay; i++) begin
      @(negedge clk);
      chk("dmem_req", dmem_req, 1);
      chk("dmem_we", dmem_we, we);
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_wstrb", dmem_wstrb, e_strb);
      if (we) chk("dmem_wdata", dmem_wdata, e_wdata);
      chk("in_ready_busy", in_ready, 0);
      if (i == delay) begin
        dmem_ack = 1; dmem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1 dmem_ack = 0;
  endtask

  initial begin
    rst = 0; in_valid = 0; alu_result = 0; store_data = 0; rd_in = 0; reg_write_in = 0;
    mem_we_in = 0; mem_re_in = 0; funct3_in = 0; dmem_ack = 0; dmem_rdata = 0;

    // Reset state, with in_valid asserted and ignored.
    #2 in_valid = 1; alu_result = 32'h77; rd_in = 5'd1; reg_write_in = 1;
    #10;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_dmem_wstrb", dmem_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 0;
    @(negedge clk) rst = 1;

    // ALU ops.
    sb_q.push_back(mk(1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b1, 1'b1));
    issue(0, 0, 32'h1234, 0, 3'b000, 5'd5, 1);
    sb_q.push_back(mk(1'b0, 5'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b1));
    issue(0, 0, 32'h1234, 0, 3'b000, 5'd0, 1);

    // SB at 0x103, ack on the third ACCESS cycle.
    mem_op(1, 0, 32'h103, 32'hAB, 3'b000, 5'd6, 1, 2, 0,
           32'h100, 32'hABAB_ABAB, 4'b1000, 1'b0, 0);
    @(negedge clk);
    chk("sb_req_drop", dmem_req, 0);
    chk("sb_in_ready", in_ready, 1);

    // SH upper half, SW with both we/re set (store wins).
    mem_op(1, 0, 32'h106, 32'h1234_BEEF, 3'b001, 5'd6, 1, 1, 0,
           32'h104, 32'hBEEF_BEEF, 4'b1100, 1'b0, 0);
    mem_op(1, 1, 32'h10C, 32'hCAFE_F00D, 3'b010, 5'd6, 1, 0, 0,
           32'h10C, 32'hCAFE_F00D, 4'b1111, 1'b0, 0);

    // Loads: LB/LBU lane 3, LH lane 2, LBU into x0.
    mem_op(0, 1, 32'h103, 0, 3'b000, 5'd7, 1, 1, 32'h80FF_7F01,
           32'h100, 0, 4'b0000, 1'b1, 32'hFFFF_FF80);
    mem_op(0, 1, 32'h103, 0, 3'b100, 5'd8, 1, 0, 32'h80FF_7F01,
           32'h100, 0, 4'b0000, 1'b1, 32'h0000_0080);
    mem_op(0, 1, 32'h102, 0, 3'b001, 5'd9, 1, 0, 32'h80FF_7F01,
           32'h100, 0, 4'b0000, 1'b1, 32'hFFFF_80FF);
    mem_op(0, 1, 32'h101, 0, 3'b100, 5'd0, 1, 0, 32'h80FF_7F01,
           32'h100, 0, 4'b0000, 1'b0, 32'h0000_007F);

    // Back-to-back: same-cycle ack load then an ALU op right after.
    mem_op(0, 1, 32'h200, 0, 3'b010, 5'd9, 1, 0, 32'h1122_3344,
           32'h200, 0, 4'b0000, 1'b1, 32'h1122_3344);
    sb_q.push_back(mk(1'b1, 5'd10, 32'h55, 1'b0, 1'b1, 1'b1));
    issue(0, 0, 32'h55, 0, 3'b000, 5'd10, 1);

`ifdef MISALIGN_CHECK_EN
    sb_q.push_back(mk(1'b0, 5'd4, 0, 1'b1, 1'b0, 1'b0));
    issue(0, 1, 32'h102, 0, 3'b010, 5'd4, 1);
    @(negedge clk);
    chk("mis_lw_no_req", dmem_req, 0);
    chk("mis_lw_in_ready", in_ready, 1);
    sb_q.push_back(mk(1'b0, 5'd4, 0, 1'b1, 1'b0, 1'b0));
    issue(1, 0, 32'h101, 32'h1, 3'b001, 5'd4, 1);
    @(negedge clk);
    chk("mis_sh_no_req", dmem_req, 0);
`else
    mem_op(0, 1, 32'h102, 0, 3'b010, 5'd4, 1, 0, 32'hDEAD_BEEF,
           32'h100, 0, 4'b0000, 1'b1, 32'hDEAD_BEEF);
`endif

    // Reset in the middle of an access, then a stray ack.
    issue(0, 1, 32'h300, 0, 3'b010, 5'd3, 1);
    @(negedge clk);
    chk("mid_req_up", dmem_req, 1);
    #2 rst = 0;
    #1;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 dmem_ack = 1; dmem_rdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1 dmem_ack = 0;
    @(negedge clk);
    chk("stray_ack_wb", wb_valid, 0);
    chk("stray_ack_req", dmem_req, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
